// File: rtl/datapath_core.sv
// datapath_core: 32-bit single-bus datapath with register file, PC/MAR/MDR, HI/LO, Y/Z and ALU
module datapath_core #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic             Read,
  input  logic             IncPC,
  input  logic [NREGS-1:0] Rin,
  input  logic [NREGS-1:0] Rout,
  input  logic             PCin,
  input  logic             Zin,
  input  logic             MDRin,
  input  logic             MARin,
  input  logic             Yin,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             PCout,
  input  logic             Zhighout,
  input  logic             Zlowout,
  input  logic             HIout,
  input  logic             LOout,
  input  logic             MDRout,
  input  logic             Cout,
  input  logic [4:0]       opcode,
  output logic [WIDTH-1:0] BusMuxOut
);
  logic [WIDTH-1:0] r [NREGS];
  logic [WIDTH-1:0] pc, mar, mdr, hi, lo, y;
  logic [2*WIDTH-1:0] z, alu, dup_r, dup_l;
  logic signed [WIDTH-1:0] sa, sb, quo, rem;
  logic signed [2*WIDTH-1:0] prod;
  logic [4:0] sh;
  assign sa = y;
  assign sb = BusMuxOut;
  assign sh = BusMuxOut[4:0];
  assign quo = sa / sb;
  assign rem = sa % sb;
  assign prod = sa * sb;
  assign dup_r = {y, y} >> sh;
  assign dup_l = {y, y} << sh;
  // bus source mux; later assignments win, so Rout[0] has the highest priority
  always_comb begin
    BusMuxOut = Cout ? {{(WIDTH-19){mdr[18]}}, mdr[18:0]} : '0;
    if (MDRout) BusMuxOut = mdr;
    if (PCout) BusMuxOut = pc;
    if (Zlowout) BusMuxOut = z[WIDTH-1:0];
    if (Zhighout) BusMuxOut = z[2*WIDTH-1:WIDTH];
    if (LOout) BusMuxOut = lo;
    if (HIout) BusMuxOut = hi;
    for (int i = NREGS - 1; i >= 0; i--)
      if (Rout[i]) BusMuxOut = r[i];
  end
  // ALU: A = Y, B = bus; IncPC overrides the opcode
  always_comb begin
    alu = '0;
    case (opcode)
      5'b00011: alu[WIDTH-1:0] = y + BusMuxOut;
      5'b00100: alu[WIDTH-1:0] = y - BusMuxOut;
      5'b00101: alu[WIDTH-1:0] = y & BusMuxOut;
      5'b00110: alu[WIDTH-1:0] = y | BusMuxOut;
      5'b00111: alu[WIDTH-1:0] = y >> sh;
      5'b01000: alu[WIDTH-1:0] = sa >>> sh;
      5'b01001: alu[WIDTH-1:0] = y << sh;
      5'b01010: alu[WIDTH-1:0] = dup_r[WIDTH-1:0];
      5'b01011: alu[WIDTH-1:0] = dup_l[2*WIDTH-1:WIDTH];
      5'b01110: alu = prod;
      5'b01111: alu = (sb == '0) ? '0 : {rem, quo};
      5'b10000: alu[WIDTH-1:0] = -BusMuxOut;
      5'b10001: alu[WIDTH-1:0] = ~BusMuxOut;
      default: alu = '0;
    endcase
    if (IncPC) alu = {{WIDTH{1'b0}}, BusMuxOut + WIDTH'(1)};
  end
  // register state: active-low synchronous clear overrides every load enable
  always_ff @(posedge Clock) begin
    if (!clear) begin
      for (int i = 0; i < NREGS; i++) r[i] <= '0;
      {pc, mar, mdr, hi, lo, y} <= '0;
      z <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (Rin[i]) r[i] <= BusMuxOut;
      if (PCin) pc <= BusMuxOut;
      if (MARin) mar <= BusMuxOut;
      if (MDRin) mdr <= Read ? Mdatain : BusMuxOut;
      if (HIin) hi <= BusMuxOut;
      if (LOin) lo <= BusMuxOut;
      if (Yin) y <= BusMuxOut;
      if (Zin) z <= alu;
    end
  end
endmodule

// File: tb/tb_datapath_core.sv
// tb_datapath_core: directed plus randomized check of datapath_core against a behavioural model
module tb_datapath_core;
  logic Clock = 1'b0;
  always #5 Clock = ~Clock;
  logic clear, Read, IncPC;
  logic [31:0] Mdatain, BusMuxOut;
  logic [15:0] Rin, Rout;
  logic PCin, Zin, MDRin, MARin, Yin, HIin, LOin;
  logic PCout, Zhighout, Zlowout, HIout, LOout, MDRout, Cout;
  logic [4:0] opcode;
  datapath_core dut (
    .Clock(Clock), .clear(clear), .Mdatain(Mdatain), .Read(Read), .IncPC(IncPC),
    .Rin(Rin), .Rout(Rout), .PCin(PCin), .Zin(Zin), .MDRin(MDRin), .MARin(MARin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .PCout(PCout), .Zhighout(Zhighout),
    .Zlowout(Zlowout), .HIout(HIout), .LOout(LOout), .MDRout(MDRout), .Cout(Cout),
    .opcode(opcode), .BusMuxOut(BusMuxOut)
  );
  int n_tests = 0;
  int n_fail = 0;
  bit skip_bus = 1'b0;
  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_mar, m_mdr, m_hi, m_lo, m_y;
  logic [63:0] m_z;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // source codes: 0..15 Ri, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR, 22 C (listed in priority order)
  function automatic logic [31:0] src_val(input int s);
    if (s < 16) return m_r[s];
    case (s)
      16: return m_hi;
      17: return m_lo;
      18: return m_z[63:32];
      19: return m_z[31:0];
      20: return m_pc;
      21: return m_mdr;
      default: return 32'($signed(m_mdr[18:0]));
    endcase
  endfunction
  function automatic bit src_on(input int s);
    if (s < 16) return Rout[s];
    case (s)
      16: return HIout;
      17: return LOout;
      18: return Zhighout;
      19: return Zlowout;
      20: return PCout;
      21: return MDRout;
      default: return Cout;
    endcase
  endfunction
  function automatic logic [31:0] exp_bus();
    for (int s = 0; s < 23; s++)
      if (src_on(s)) return src_val(s);
    return 32'd0;
  endfunction
  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic inc);
    int sa, sb;
    int unsigned s;
    logic [31:0] v;
    sa = a;
    sb = b;
    s = b[4:0];
    if (inc) return {32'd0, b + 32'd1};
    if (op == 5'd14) return 64'(longint'(sa) * longint'(sb));
    if (op == 5'd15) return (sb == 0) ? 64'd0 : {32'(sa % sb), 32'(sa / sb)};
    case (op)
      5'd3: v = a + b;
      5'd4: v = a - b;
      5'd5: v = a & b;
      5'd6: v = a | b;
      5'd7: v = a >> s;
      5'd8: v = 32'(sa >>> s);
      5'd9: v = a << s;
      5'd10: v = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
      5'd11: v = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
      5'd16: v = -b;
      5'd17: v = ~b;
      default: v = 32'd0;
    endcase
    return {32'd0, v};
  endfunction
  task automatic idle();
    Rin = '0; Rout = '0; Read = 0; IncPC = 0; opcode = '0;
    {PCin, Zin, MDRin, MARin, Yin, HIin, LOin} = '0;
    {PCout, Zhighout, Zlowout, HIout, LOout, MDRout, Cout} = '0;
  endtask
  task automatic set_src(input int s);
    if (s < 16) Rout[s] = 1'b1;
    else case (s)
      16: HIout = 1'b1;
      17: LOout = 1'b1;
      18: Zhighout = 1'b1;
      19: Zlowout = 1'b1;
      20: PCout = 1'b1;
      21: MDRout = 1'b1;
      default: Cout = 1'b1;
    endcase
  endtask
  // one clock: check the bus, then advance the model with the strobes held this cycle
  task automatic cyc();
    logic [31:0] b;
    logic [63:0] res;
    #1;
    b = exp_bus();
    if (!skip_bus) check("bus", BusMuxOut, b);
    res = ref_alu(opcode, m_y, b, IncPC);
    @(posedge Clock);
    if (!clear) begin
      for (int i = 0; i < 16; i++) m_r[i] = 0;
      {m_pc, m_mar, m_mdr, m_hi, m_lo, m_y} = '0;
      m_z = 0;
    end else begin
      for (int i = 0; i < 16; i++) if (Rin[i]) m_r[i] = b;
      if (PCin) m_pc = b;
      if (MARin) m_mar = b;
      if (MDRin) m_mdr = Read ? Mdatain : b;
      if (HIin) m_hi = b;
      if (LOin) m_lo = b;
      if (Yin) m_y = b;
      if (Zin) m_z = res;
    end
    @(negedge Clock);
  endtask
  task automatic rd(input int s, input logic [31:0] exp, input string tag);
    idle();
    set_src(s);
    #1 check(tag, BusMuxOut, exp);
    cyc();
  endtask
  task automatic ld_r(input int i, input logic [31:0] v);
    idle(); Mdatain = v; Read = 1; MDRin = 1; cyc();
    idle(); MDRout = 1; Rin[i] = 1; cyc();
  endtask
  task automatic alu_op(input int ra, input int rb, input logic [4:0] op, input int dst);
    idle(); Rout[ra] = 1; Yin = 1; cyc();
    idle(); Rout[rb] = 1; opcode = op; Zin = 1; cyc();
    idle(); Zlowout = 1; Rin[dst] = 1; cyc();
  endtask
  task automatic all_zero(input string tag);
    for (int s = 0; s < 23; s++) rd(s, 32'd0, $sformatf("%s_src%0d", tag, s));
    check({tag, "_mar"}, dut.mar, 32'd0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    idle();
    clear = 0;
    Mdatain = 32'hDEADBEEF;
    @(negedge Clock);
    Rin = '1; {PCin, Zin, MDRin, MARin, Yin, HIin, LOin} = '1; Read = 1; Rout[4] = 1;
    skip_bus = 1;
    cyc();
    skip_bus = 0;
    clear = 1;
    all_zero("rst");
    idle();
    #1 check("idle_bus", BusMuxOut, 32'd0);
    cyc();
    ld_r(3, 32'h12); ld_r(5, 32'h14); ld_r(1, 32'h18);
    rd(3, 32'h12, "ld_r3"); rd(5, 32'h14, "ld_r5"); rd(1, 32'h18, "ld_r1");
    alu_op(3, 5, 5'b01000, 1);
    rd(1, 32'h0, "shra_small");
    ld_r(3, 32'h80000000); ld_r(5, 32'd4);
    alu_op(3, 5, 5'b01000, 1);
    rd(1, 32'hF8000000, "shra_neg");
    for (int k = 0; k < 3; k++) begin
      idle(); PCout = 1; MARin = 1; IncPC = 1; Zin = 1; cyc();
      idle(); Zlowout = 1; PCin = 1; cyc();
      if (k == 0) begin
        rd(20, 32'd1, "pc_inc1");
        check("mar_pc0", dut.mar, 32'd0);
      end
    end
    rd(20, 32'd3, "pc_inc3");
    check("mar_pc2", dut.mar, 32'd2);
    ld_r(6, -32'sd6); ld_r(7, 32'd4); ld_r(8, 32'd0);
    idle(); Rout[6] = 1; Yin = 1; cyc();
    idle(); Rout[7] = 1; opcode = 5'b01110; Zin = 1; cyc();
    rd(18, 32'hFFFFFFFF, "mul_hi"); rd(19, 32'hFFFFFFE8, "mul_lo");
    idle(); Rout[7] = 1; opcode = 5'b01111; Zin = 1; cyc();
    rd(19, 32'hFFFFFFFF, "div_quo"); rd(18, 32'hFFFFFFFE, "div_rem");
    idle(); Rout[8] = 1; opcode = 5'b01111; Zin = 1; cyc();
    rd(18, 32'd0, "div0_hi"); rd(19, 32'd0, "div0_lo");
    ld_r(2, 32'h0000ABCD);
    idle(); Rout[2] = 1; PCout = 1;
    #1 check("prio_r2_pc", BusMuxOut, 32'h0000ABCD);
    cyc();
    idle(); Mdatain = 32'h00040000; Read = 1; MDRin = 1; cyc();
    idle(); Cout = 1;
    #1 check("cout_sext", BusMuxOut, 32'hFFFC0000);
    cyc();
    idle(); Cout = 1; MDRout = 1;
    #1 check("prio_mdr_c", BusMuxOut, 32'h00040000);
    cyc();
    idle(); clear = 0; Rin = '1; {PCin, Zin, MDRin, MARin, Yin, HIin, LOin} = '1; Read = 1; Rout[2] = 1;
    cyc();
    clear = 1;
    all_zero("rst2");
    for (int k = 0; k < 3000; k++) begin
      idle();
      clear = ($urandom_range(0, 99) != 0);
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) set_src($urandom_range(0, 22));
      Rin = 16'($urandom & $urandom & $urandom);
      {PCin, Zin, MDRin, MARin, Yin, HIin, LOin} = 7'($urandom & $urandom);
      Read = $urandom_range(0, 1) == 1;
      IncPC = $urandom_range(0, 7) == 0;
      opcode = 5'($urandom_range(0, 18));
      Mdatain = $urandom;
      cyc();
    end
    clear = 1;
    for (int s = 0; s < 23; s++) rd(s, src_val(s), $sformatf("final_src%0d", s));
    check("final_mar", dut.mar, m_mar);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
